// File: rtl/spi_reg_master.sv
// SPI mode-0 register-access initiator: one read/write command per frame, 9-bit header,
// dummy cycles on reads, then 8/16/32 data bits MSB first, one-cycle response strobe.
module spi_reg_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned READ_DUMMY = 8,
  parameter int unsigned CS_GAP     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_width,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned PhaseW = $clog2(CLK_DIV + 1);
  localparam int unsigned BitW   = $clog2(9 + READ_DUMMY + 32 + 1);
  localparam int unsigned GapW   = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {StIdle, StShift, StDummy, StData, StTail, StGap} state_e;

  state_e            state_q;
  logic [PhaseW-1:0] phase_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [GapW-1:0]   gap_q;
  logic [40:0]       tx_q;
  logic [31:0]       rx_q;
  logic              write_q;
  logic [1:0]        width_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              cs_n_q;
  logic              sck_q;
  logic              mosi_q;

  logic [31:0] wdata_aligned;
  logic [5:0]  data_bits;
  logic        phase_last;

  // Write data is left-aligned so the frame always shifts out of tx_q[40].
  always_comb begin
    wdata_aligned = cmd_wdata;
    case (cmd_width)
      2'b00:   wdata_aligned = {cmd_wdata[7:0], 24'd0};
      2'b01:   wdata_aligned = {cmd_wdata[15:0], 16'd0};
      default: wdata_aligned = cmd_wdata;
    endcase
  end

  always_comb begin
    data_bits = width_q[1] ? 6'd32 : (width_q[0] ? 6'd16 : 6'd8);
  end

  assign phase_last = (phase_q == PhaseW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      gap_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      write_q     <= 1'b0;
      width_q     <= 2'b00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready_q) begin
            write_q     <= cmd_write;
            width_q     <= cmd_width;
            tx_q        <= {cmd_write, cmd_width, cmd_addr, cmd_write ? wdata_aligned : 32'd0};
            rx_q        <= '0;
            mosi_q      <= cmd_write;
            cs_n_q      <= 1'b0;
            sck_q       <= 1'b0;
            phase_q     <= '0;
            bit_cnt_q   <= BitW'(9);
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StShift;
          end
        end
        StShift, StDummy, StData: begin
          if (!phase_last) begin
            phase_q <= phase_q + PhaseW'(1);
          end else begin
            phase_q <= '0;
            sck_q   <= ~sck_q;
            // Last cycle of the high phase: sample MISO and move to the next bit.
            if (sck_q) begin
              if (state_q == StData && !write_q) begin
                rx_q <= {rx_q[30:0], spi_miso};
              end
              tx_q      <= {tx_q[39:0], 1'b0};
              mosi_q    <= tx_q[39];
              bit_cnt_q <= bit_cnt_q - BitW'(1);
              if (bit_cnt_q == BitW'(1)) begin
                if (state_q == StShift && !write_q && READ_DUMMY != 0) begin
                  state_q   <= StDummy;
                  bit_cnt_q <= BitW'(READ_DUMMY);
                end else if (state_q != StData) begin
                  state_q   <= StData;
                  bit_cnt_q <= BitW'(data_bits);
                end else begin
                  state_q <= StTail;
                  mosi_q  <= 1'b0;
                end
              end
            end
          end
        end
        StTail: begin
          if (!phase_last) begin
            phase_q <= phase_q + PhaseW'(1);
          end else begin
            phase_q     <= '0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rx_q;
            gap_q       <= '0;
            state_q     <= StGap;
          end
        end
        StGap: begin
          if (gap_q == GapW'(CS_GAP - 1)) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI initiator that drives the register-access protocol served by the peripheral harness's SPI register slave. Address space: 6-bit address, 8/16/32-bit transactions.
- Accepts one register read/write command at a time over a valid/ready interface, serialises it as an SPI mode-0 frame, and returns read data on a one-cycle response strobe.
- Used as the host-side driver in integration benches and in FPGA bring-up logic.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles; legal minimum 2.
- READ_DUMMY, 8: SCK cycles inserted between header and read data, covering slave synchroniser and data_ready latency.
- CS_GAP, 8: minimum clk cycles cs_n stays high between frames.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_width  in  2  00 = 8-bit, 01 = 16-bit, 1x = 32-bit.
- cmd_addr  in  6  register address.
- cmd_wdata  in  32  write data; only the low N bits are used.
- rsp_valid  out  1  one-cycle pulse on frame completion (reads and writes).
- rsp_rdata  out  32  read data, zero-extended; 0 after a write.
- busy  out  1  high from command accept until cmd_ready re-asserts.
- spi_cs_n  out  1  chip select, active low.
- spi_sck  out  1  serial clock, idle low.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in; asynchronous to clk, sampled directly with no internal synchroniser.

Behaviour:
- Reset values:
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0.
  - spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - FSM in IDLE.
- Accept and latch:
  - A command is accepted in the cycle where cmd_valid && cmd_ready.
  - All cmd_* fields are latched on accept.
  - cmd_ready falls the next cycle.
- Frame format, MSB first:
  - 9-bit header: {cmd_write, cmd_width[1:0], cmd_addr[5:0]}.
  - Write: followed by N data bits, cmd_wdata[N-1:0], N = 8/16/32.
  - Read: followed by READ_DUMMY dummy cycles with MOSI=0, then N data bits with MOSI=0.
- Bit timing (mode 0):
  - Each bit has a low phase of CLK_DIV cycles (MOSI driven/changed at the start) and a high phase of CLK_DIV cycles.
  - MISO is sampled on the last clk cycle of each high phase.
  - MISO bits are shifted in MSB first into the low N bits of rsp_rdata.
- States: IDLE -> SHIFT (header) -> DUMMY (reads only) -> DATA -> TAIL -> GAP -> IDLE.
- Frame edges:
  - Accept at cycle T: at T+1 spi_cs_n=0, spi_sck=0, spi_mosi=header bit 8.
  - After the last high phase, TAIL holds sck low for CLK_DIV cycles, then spi_cs_n=1.
  - Total cs_n-low time = 2*CLK_DIV*bits + CLK_DIV, with bits = 9 + (read ? READ_DUMMY : 0) + N.
- Completion:
  - rsp_valid pulses for exactly one cycle, in the same cycle spi_cs_n returns high.
  - rsp_rdata is updated in that cycle and held until the next completion.
- GAP and idle:
  - GAP holds cs_n high for CS_GAP cycles; cmd_ready and busy=0 then return in the following cycle.
  - spi_mosi is driven 0 whenever cs_n is high.
- Width 11 behaves identically to 10, and the header carries 11 verbatim.
- cmd_valid while not ready is ignored, with no queuing; the requester holds it.
- Reset mid-frame: next cycle spi_cs_n=1, spi_sck=0, spi_mosi=0, FSM in IDLE, cmd_ready=1; no rsp_valid is generated; rsp_rdata is cleared to 0.
- Counters:
  - Phase counter counts 0..CLK_DIV-1.
  - Bit counter is sized for 9+READ_DUMMY+32, with no wrap inside a frame.

Test Plan:
- Reset then idle 20 cycles -> cs_n=1, sck=0, mosi=0, cmd_ready=1, rsp_valid never asserted.
- CLK_DIV=2, write width=10 addr=0x05 wdata=0xDEADBEEF -> 41 sck rising edges.
  - MOSI at the rises: 1,10,000101, then 0xDEADBEEF MSB first.
  - cs_n low exactly 166 cycles; rsp_valid one pulse with rsp_rdata=0.
- CLK_DIV=2, READ_DUMMY=8, read width=00 addr=0x3F, slave model returns 0xA5 after the dummy cycles -> 25 rising edges, header 0,00,111111; rsp_rdata=0x000000A5.
- Read width=01, slave returns 0x1234, then second cmd_valid held high during the frame -> second command accepted only after CS_GAP cs_n-high cycles; rsp_rdata=0x00001234 on the first completion.
- Read width=11 with slave returning 0x80000001 -> 32 data bits, rsp_rdata=0x80000001, header width bits 11.
- Assert rst at the 20th sck edge of a write -> next cycle cs_n=1, sck=0, cmd_ready=1; no rsp_valid; a following write completes normally.
